serializzatore: RTL and testbench
=================================

// Module: serializzatore
// PURPOSE
//  Parallel-to-serial transmitter: captures an N-bit word on a start/ready handshake and emits it
//  one bit per clock, LSB first, with a per-bit valid strobe and a one-cycle completion pulse.
//  Read/transmit side of the enable-loaded register: the datapath's register output feeds x and
//  the serial link leaves on z/zv.
// PARAMETERS
//  N   8   word width in bits; legal range N >= 1
// PORTS
//  clk    in   1   clock; all state updates on posedge clk
//  rst    in   1   synchronous reset, active-high
//  x      in   N   parallel word; sampled only on the accepting edge
//  start  in   1   request to transmit x
//  ready  out  1   1 = idle, next start is accepted
//  z      out  1   serial data bit; meaningful only when zv=1
//  zv     out  1   serial bit valid
//  done   out  1   one-cycle pulse after the last transmitted bit
// BEHAVIOUR
//  - One clock, clk; reset is synchronous and active-high (rst sampled on posedge clk).
//  - After any edge with rst=1: state IDLE, ready=1, z=0, zv=0, done=0, shift reg=0, bit counter=0.
//  - rst has priority over everything. Reset mid-transmission aborts the word immediately; no done.
//  - States: IDLE -> SHIFT -> [PAR] -> DONE -> IDLE. All outputs are driven from registers.
//  - IDLE: ready=1, zv=0, done=0. start=1 at edge k: s<=x, cnt<=0, go SHIFT. start=0: stay IDLE.
//  - SHIFT: ready=0, zv=1, z=s[0]. Each edge: s<=s>>1, cnt<=cnt+1. At cnt==N-1 go PAR (if enabled)
//    or go DONE.
//  - Timing (no parity): accepted at edge k -> bit i valid in cycle k+1+i (i=0..N-1);
//    done=1 in cycle k+N+1; ready=1 again from cycle k+N+2.
//  - DONE: done=1, zv=0, ready=0 for exactly one cycle, then go IDLE.
//  - start while ready=0 is ignored, not queued. x changes after acceptance have no effect.
//  - start held high continuously: back-to-back words separated by exactly one DONE cycle
//    plus one IDLE cycle.
//  - N=1: SHIFT lasts one cycle. Counter width CW = (N>1) ? $clog2(N) : 1; cnt never exceeds N-1.
// CONFIGURATION
//  - Macro SERIALIZZATORE_PARITY_EN.
//  - Defined: the captured word's even parity (XOR of all N bits, registered at acceptance) is sent
//    as one extra bit in state PAR, with zv=1 and z=parity. done and ready shift one cycle later
//    (done in cycle k+N+2).
//  - Not defined: PAR state, parity register and the extra cycle do not exist; timing is as above.
// STRUCTURE
//  - Shared header serializzatore_defs.vh holds the state encoding localparams
//    (S_IDLE=0, S_SHIFT=1, S_PAR=2, S_DONE=3), the 2-bit state width, and the CW expression.
//  - One natural sub-module: contatore_bit, a CW-bit counter with sync clear and enable, counting
//    up to N-1 and asserting a terminal-count flag at cnt==N-1.
//  - The FSM and the shift register stay in the top module.
// TESTING (N=8 unless stated)
//  - Reset: hold rst for 2 edges, then release -> ready=1, zv=0, done=0, z=0.
//  - Single word: x=8'hA5, start pulsed at edge k -> z over cycles k+1..k+8 = 1,0,1,0,0,1,0,1;
//    zv=1 exactly in those cycles; done=1 only in cycle k+9; ready=1 from cycle k+10.
//  - Busy ignore: start=1 with x=8'hFF during SHIFT of 8'h3C -> serial stream is still
//    0,0,1,1,1,1,0,0 and exactly one done pulse.
//  - Reset mid-operation: rst=1 at 4th bit of 8'hF0 -> next cycle zv=0, ready=1, no done;
//    new start with x=8'h01 transmits 1,0,0,0,0,0,0,0 correctly.
//  - Back-to-back: start held high with x=8'h81 -> two done pulses 10 cycles apart,
//    both streams 1,0,0,0,0,0,0,1.
//  - SERIALIZZATORE_PARITY_EN, x=8'h07 -> 8 data bits, then z=1 with zv=1 in cycle k+9,
//    done in cycle k+10; repeat with N=1 and x=1 -> bit 1, parity 1, done in cycle k+3.

Source files
------------

// File: rtl/serializzatore_pkg.sv
// Shared types for the serializzatore parallel-to-serial transmitter.
// State encoding and the bit-counter width rule.
package serializzatore_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serializzatore_if.sv
// Word-in / serial-out bundle of the serializzatore.
// master drives the word and start, slave returns the serial link.
interface serializzatore_if #(
  parameter int N = 8
) ();

  logic [N-1:0] x;
  logic         start;
  logic         ready;
  logic         z;
  logic         zv;
  logic         done;

  modport master (
    output x, start,
    input  ready, z, zv, done
  );

  modport slave (
    input  x, start,
    output ready, z, zv, done
  );

endinterface

// File: rtl/serializzatore_contatore_bit.sv
// contatore_bit: saturating bit counter with sync clear and enable.
// o_tc flags the last bit position (cnt == N-1).
module contatore_bit
  import serializzatore_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = cnt_w(N);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(N - 1));
  assign o_tc = w_tc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serializzatore.sv
// serializzatore: N-bit word out LSB first with per-bit valid and done pulse.
// Define SERIALIZZATORE_PARITY_EN to append an even-parity bit to each word.
module serializzatore
  import serializzatore_pkg::*;
#(
  parameter int N = 8
) (
  input logic             clk,
  input logic             rst,
  serializzatore_if.slave bus
);

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_s;
  logic [N-1:0] w_s;
  logic         r_ready;
  logic         r_z;
  logic         r_zv;
  logic         r_done;
  logic         w_z;
  logic         w_acc;
  logic         w_tc;

  assign w_acc = (r_state == S_IDLE) && bus.start;

  contatore_bit #(
    .N(N)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_acc),
    .i_en (r_state == S_SHIFT),
    .o_tc (w_tc)
  );

`ifdef SERIALIZZATORE_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_acc) begin
      r_par <= ^bus.x;
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    w_s    = r_s;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_SHIFT;
          w_s    = bus.x;
        end
      end
      S_SHIFT: begin
        w_s = r_s >> 1;
        if (w_tc) begin
`ifdef SERIALIZZATORE_PARITY_EN
          w_next = S_PAR;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef SERIALIZZATORE_PARITY_EN
      S_PAR:   w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs are registered from the state being entered
  always_comb begin
    w_z = 1'b0;
    if (w_next == S_SHIFT) begin
      w_z = w_s[0];
    end
`ifdef SERIALIZZATORE_PARITY_EN
    else if (w_next == S_PAR) begin
      w_z = r_par;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_ready <= 1'b1;
      r_z     <= 1'b0;
      r_zv    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_s     <= w_s;
      r_ready <= (w_next == S_IDLE);
      r_z     <= w_z;
      r_zv    <= (w_next == S_SHIFT)
              || (w_next == S_PAR);
      r_done  <= (w_next == S_DONE);
    end
  end

  assign bus.ready = r_ready;
  assign bus.z     = r_z;
  assign bus.zv    = r_zv;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_serializzatore.sv
// Bench for serializzatore: N=8 and N=1 instances against a
// per-cycle expected-output queue model.
module tb_serializzatore;

  localparam int N = 8;
  localparam logic [3:0] IDLE_R = 4'b1000;

`ifdef SERIALIZZATORE_PARITY_EN
  localparam int GAP = N + 3;
`else
  localparam int GAP = N + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serializzatore_if #(.N(N)) b8 ();
  serializzatore_if #(.N(1)) b1 ();

  serializzatore #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b8)
  );

  serializzatore #(.N(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // each entry: {ready, zv, z, done} for one future cycle
  logic [3:0] q8[$];
  logic [3:0] q1[$];
  logic [3:0] c8 = IDLE_R;
  logic [3:0] c1 = IDLE_R;
  int         done8[$];

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive(logic s, logic [N-1:0] w);
    b8.start = s;
    b8.x     = w;
    b1.start = s;
    b1.x     = w[0];
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      q8.delete();
      q1.delete();
      c8 = IDLE_R;
      c1 = IDLE_R;
    end else begin
      if (c8[3] && b8.start) begin
        for (int i = 0; i < N; i++)
          q8.push_back({2'b01, b8.x[i], 1'b0});
`ifdef SERIALIZZATORE_PARITY_EN
        q8.push_back({2'b01, ^b8.x, 1'b0});
`endif
        q8.push_back(4'b0001);
      end
      if (c1[3] && b1.start) begin
        q1.push_back({2'b01, b1.x[0], 1'b0});
`ifdef SERIALIZZATORE_PARITY_EN
        q1.push_back({2'b01, b1.x[0], 1'b0});
`endif
        q1.push_back(4'b0001);
      end
      c8 = (q8.size() != 0) ? q8.pop_front() : IDLE_R;
      c1 = (q1.size() != 0) ? q1.pop_front() : IDLE_R;
    end
    @(negedge clk);
    chk("n8_ready", b8.ready, c8[3]);
    chk("n8_zv", b8.zv, c8[2]);
    chk("n8_done", b8.done, c8[0]);
    if (c8[2]) chk("n8_z", b8.z, c8[1]);
    chk("n1_ready", b1.ready, c1[3]);
    chk("n1_zv", b1.zv, c1[2]);
    chk("n1_done", b1.done, c1[0]);
    if (c1[2]) chk("n1_z", b1.z, c1[1]);
    if (b8.done) done8.push_back(cyc);
  endtask

  initial begin
    int nd;
    drive(1'b0, '0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", b8.ready, 1'b1);
    chk("rst_zv", b8.zv, 1'b0);
    chk("rst_done", b8.done, 1'b0);
    chk("rst_z", b8.z, 1'b0);
    rst = 1'b0;

    // single word
    drive(1'b1, 8'hA5);
    tick();
    drive(1'b0, 8'h5A);
    repeat (12) tick();

    // start during shift is ignored
    done8.delete();
    drive(1'b1, 8'h3C);
    tick();
    drive(1'b0, 8'h00);
    repeat (3) tick();
    drive(1'b1, 8'hFF);
    repeat (3) tick();
    drive(1'b0, 8'hFF);
    repeat (8) tick();
    chk_int("busy_done_cnt", done8.size(), 1);

    // reset while the 4th bit is on the wire
    drive(1'b1, 8'hF0);
    tick();
    drive(1'b0, 8'h00);
    repeat (4) tick();
    done8.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", b8.ready, 1'b1);
    chk("abort_zv", b8.zv, 1'b0);
    repeat (3) tick();
    chk_int("abort_no_done", done8.size(), 0);
    drive(1'b1, 8'h01);
    tick();
    drive(1'b0, 8'h00);
    repeat (12) tick();

    // start held high
    done8.delete();
    drive(1'b1, 8'h81);
    repeat (2 * GAP + 1) tick();
    drive(1'b0, 8'h00);
    nd = done8.size();
    chk_int("b2b_done_cnt", nd, 2);
    if (nd >= 2)
      chk_int("b2b_gap", done8[1] - done8[0], GAP);
    repeat (GAP) tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 2) != 0,
            N'($urandom));
      tick();
    end
    rst = 1'b0;
    drive(1'b0, '0);
    repeat (GAP + 2) tick();
    chk("end_ready", b8.ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
